sdu_cmd_ctrl: RTL and testbench
===============================

# sdu_cmd_ctrl

Command controller of the serial debug unit: consumes bytes from the UART receiver, decodes a binary debug protocol, and drives the CPU pipeline's debug port (`debug`, `addr`, `din`, `we_im`, `we_dm`, `clk_ld`) plus run/step control. It samples `dout_im`/`dout_dm`/`dout_rf` for read-back and returns response bytes to the UART transmitter. It sits directly upstream of `CPU_PIPELINE`'s load/debug inputs.

## Interface
- `READ_WAIT`, 2: cycles between driving `addr` and sampling `dout_*` (1..15).
- `TIMEOUT_CYC`, 1_000_000: idle cycles between argument bytes before a command is aborted.
- `clk` in 1: system clock; all logic on rising edge.
- `rstn` in 1: reset; one clock; reset is asynchronous and active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid; no backpressure.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response byte available.
- `tx_ready` in 1: transmitter accepts byte when `tx_valid & tx_ready`.
- `dout_im`, `dout_dm`, `dout_rf` in 32: CPU memory/regfile read data at `addr`.
- `debug` out 1: CPU debug-mux select; equals `~run`.
- `addr` out 32: debug address; `dout_rf` uses `addr[4:0]`.
- `din` out 32: write data.
- `we_im`, `we_dm` out 1: write enables.
- `clk_ld` out 1: load strobe.
- `run` out 1: CPU free-running enable.
- `step` out 1: one-cycle single-step request.
- `err_ovr` out 1: sticky, a byte arrived while busy.

## Operation
- Frame: command byte, then arguments, all 32-bit values little-endian (LSB first).
- `0x49` 'I': addr(4) data(4) → write IM, reply `0x06`.
- `0x44` 'D': addr(4) data(4) → write DM, reply `0x06`.
- `0x50` 'P' / `0x4D` 'M' / `0x47` 'G': addr(4) → reply 4 bytes of `dout_im` / `dout_dm` / `dout_rf`, LSB first.
- `0x53` 'S': if halted, pulse `step`, reply `0x06`; if running, reply `0x15`.
- `0x43` 'C': `run`←1. `0x48` 'H': `run`←0. Both reply `0x06`.
- Any other command byte: reply `0x15` (NAK), return to IDLE.
- Memory commands ('I','D','P','M','G') while `run`=1: arguments are consumed, no memory access, reply `0x15`.
- States: IDLE → ARG (byte counter 0..7, shifts into addr/data regs) → WR_SETUP → WR_STROBE → RESP, or ARG → RD_WAIT → RESP; single-byte commands go IDLE → RESP.
- RESP sends 1 or 4 bytes from a shift register, then IDLE.
- Timeout: in ARG, a counter resets on each `rx_valid`. Reaching `TIMEOUT_CYC` aborts to IDLE with no reply and no memory access.
- Bytes arriving outside IDLE/ARG are dropped and set `err_ovr`. `err_ovr` clears only on reset or on a new 'H' command.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `addr`=0, `din`=0, `we_im`=`we_dm`=`clk_ld`=0, `run`=0, `debug`=1, `step`=0, `err_ovr`=0, state IDLE.
- Write, last data byte strobe at cycle T:
  - `addr`/`din`/`we_*` valid from T+1.
  - `clk_ld`=1 at T+2 only.
  - `we_*` deasserts at T+3; `addr`/`din` hold until the next command.
  - `tx_valid`=1 with `0x06` at T+3.
- Read, last addr byte at T: `addr` valid T+1; `dout_*` sampled at end of cycle T+READ_WAIT; first `tx_valid` at T+READ_WAIT+1.
- Step: 'S' at T → `step`=1 at T+1 only; ACK `tx_valid` at T+2.
- 'C'/'H' at T: `run` updates at T+1; ACK at T+1.
- `tx_valid` stays high and `tx_data` stays stable until accepted. The next byte presents the cycle after acceptance, so the rate is one byte per cycle if `tx_ready` is held high.
- `rx_valid` in the same cycle as the timeout terminal count: the byte is accepted and the timeout is not taken.
- Async reset mid-write forces `we_*`/`clk_ld` low immediately; no partial reply is sent.

## Structure
- Package `sdu_pkg`: command codes, `ACK`=`0x06`, `NAK`=`0x15`, state enum, and the response-length constant.
- One sub-module `sdu_tx_shift`: a 4-byte LSB-first response shifter with the valid/ready handshake.
- The decoder/FSM, argument assembly and timeout counter live in the top module.

## Test plan
- Reset, then 'C','H': two `0x06` replies; `run` goes 1 then 0; `debug` follows `~run`.
- 'I' `00 10 00 00` `13 00 50 00`: `addr`=`0x00001000`, `din`=`0x00500013`, `we_im`=1, one-cycle `clk_ld`, reply `0x06`.
- 'M' with addr `0x0000000C`, model `dout_dm`=`0xDEADBEEF`: replies `EF BE AD DE`, with `tx_ready` toggled every other cycle; bytes must not be lost or repeated.
- 'S' while halted: one-cycle `step`, `0x06`. 'S' after 'C': no `step`, reply `0x15`. 'D' after 'C': no `we_dm`, reply `0x15`.
- Byte `0x7A`: reply `0x15`. 'D' then 3 bytes then silence ≥ `TIMEOUT_CYC` (sim param 16): no write, no reply, next 'H' is ACKed.
- `rx_valid` during RESP: byte dropped, `err_ovr`=1. Assert `rstn`=0 between `clk_ld` setup and strobe: no `clk_ld` pulse, all outputs at reset values.

Source files
------------

// File: rtl/sdu_pkg.sv
// Shared definitions for the serial debug unit command controller:
// protocol codes, FSM states and the response-shifter load payload.
package sdu_pkg;

  localparam logic [7:0] CMD_WR_IM = 8'h49;
  localparam logic [7:0] CMD_WR_DM = 8'h44;
  localparam logic [7:0] CMD_RD_IM = 8'h50;
  localparam logic [7:0] CMD_RD_DM = 8'h4D;
  localparam logic [7:0] CMD_RD_RF = 8'h47;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_HALT  = 8'h48;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam int unsigned RESP_LEN = 4;
  localparam int unsigned LEN_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [LEN_W-1:0] len;
  } tx_load_t;

  function automatic logic is_wr_cmd(input logic [7:0] c);
    return (c == CMD_WR_IM) || (c == CMD_WR_DM);
  endfunction

  function automatic logic is_rd_cmd(input logic [7:0] c);
    return (c == CMD_RD_IM) || (c == CMD_RD_DM) || (c == CMD_RD_RF);
  endfunction

  function automatic tx_load_t resp_byte(input logic [7:0] b);
    tx_load_t p;
    p.data = {24'h0, b};
    p.len  = LEN_W'(1);
    return p;
  endfunction

endpackage

// File: rtl/sdu_cmd_ctrl_if.sv
// UART byte streams plus CPU debug port of the command controller.
// master = controller side, slave = UART/CPU side.
interface sdu_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] dout_im;
  logic [31:0] dout_dm;
  logic [31:0] dout_rf;
  logic        debug;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we_im;
  logic        we_dm;
  logic        clk_ld;
  logic        run;
  logic        step;
  logic        err_ovr;

  modport master (
    input  rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf,
    output tx_data, tx_valid, debug, addr, din, we_im, we_dm, clk_ld, run, step, err_ovr
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf,
    input  tx_data, tx_valid, debug, addr, din, we_im, we_dm, clk_ld, run, step, err_ovr
  );
endinterface

// File: rtl/sdu_tx_shift.sv
// Response shifter: holds up to four bytes and presents them LSB first
// on a valid/ready handshake, one byte per accepted cycle.
module sdu_tx_shift
  import sdu_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     i_load,
  input  tx_load_t i_payload,
  input  logic     i_ready,
  output logic [7:0] o_data,
  output logic     o_valid
);

  logic [31:0]      r_sh;
  logic [LEN_W-1:0] r_left;
  logic             r_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sh    <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_sh    <= i_payload.data;
      r_left  <= i_payload.len;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_sh    <= {8'h00, r_sh[31:8]};
      r_left  <= r_left - LEN_W'(1);
      r_valid <= (r_left != LEN_W'(1));
    end
  end

  assign o_data  = r_sh[7:0];
  assign o_valid = r_valid;

endmodule

// File: rtl/sdu_cmd_ctrl.sv
// Debug-protocol decoder: assembles little-endian arguments from the UART,
// drives the CPU debug port and queues replies into the response shifter.
module sdu_cmd_ctrl
  import sdu_pkg::*;
#(
  parameter int unsigned READ_WAIT   = 2,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic           clk,
  input  logic           rstn,
  sdu_cmd_ctrl_if.master bus
);

  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RW_W   = 4;
  localparam int unsigned BCNT_W = 3;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cmd, w_cmd_nxt;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_nxt;
  logic [TO_W-1:0]   r_tcnt, w_tcnt_nxt;
  logic [RW_W-1:0]   r_wcnt, w_wcnt_nxt;
  logic [31:0]       r_addr, w_addr_nxt;
  logic [31:0]       r_din, w_din_nxt;
  logic              r_we_im, w_we_im_nxt;
  logic              r_we_dm, w_we_dm_nxt;
  logic              r_clk_ld, w_clk_ld_nxt;
  logic              r_run, w_run_nxt;
  logic              r_debug;
  logic              r_step, w_step_nxt;
  logic              r_err_ovr, w_err_ovr_nxt;
  logic              r_pend, w_pend_nxt;

  logic              w_load;
  tx_load_t          w_payload;
  logic [31:0]       w_rd_data;
  logic [7:0]        w_tx_data;
  logic              w_tx_valid;

  assign w_rd_data = (r_cmd == CMD_RD_IM) ? bus.dout_im :
                     (r_cmd == CMD_RD_DM) ? bus.dout_dm : bus.dout_rf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_bcnt    <= '0;
      r_tcnt    <= '0;
      r_wcnt    <= '0;
      r_addr    <= '0;
      r_din     <= '0;
      r_we_im   <= 1'b0;
      r_we_dm   <= 1'b0;
      r_clk_ld  <= 1'b0;
      r_run     <= 1'b0;
      r_debug   <= 1'b1;
      r_step    <= 1'b0;
      r_err_ovr <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd     <= w_cmd_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_addr    <= w_addr_nxt;
      r_din     <= w_din_nxt;
      r_we_im   <= w_we_im_nxt;
      r_we_dm   <= w_we_dm_nxt;
      r_clk_ld  <= w_clk_ld_nxt;
      r_run     <= w_run_nxt;
      r_debug   <= ~w_run_nxt;
      r_step    <= w_step_nxt;
      r_err_ovr <= w_err_ovr_nxt;
      r_pend    <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_nxt     = r_cmd;
    w_bcnt_nxt    = r_bcnt;
    w_tcnt_nxt    = r_tcnt;
    w_wcnt_nxt    = r_wcnt;
    w_addr_nxt    = r_addr;
    w_din_nxt     = r_din;
    w_we_im_nxt   = r_we_im;
    w_we_dm_nxt   = r_we_dm;
    w_clk_ld_nxt  = 1'b0;
    w_run_nxt     = r_run;
    w_step_nxt    = 1'b0;
    w_err_ovr_nxt = r_err_ovr;
    w_pend_nxt    = r_pend;
    w_load        = 1'b0;
    w_payload     = '0;

    // Only IDLE and ARG consume bytes; anything else is an overrun.
    if (bus.rx_valid && (r_state != ST_IDLE) && (r_state != ST_ARG)) begin
      w_err_ovr_nxt = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          w_cmd_nxt = bus.rx_data;
          if (is_wr_cmd(bus.rx_data) || is_rd_cmd(bus.rx_data)) begin
            w_bcnt_nxt  = '0;
            w_tcnt_nxt  = '0;
            w_state_nxt = ST_ARG;
          end else begin
            w_state_nxt = ST_RESP;
            if (bus.rx_data == CMD_RUN) begin
              w_run_nxt = 1'b1;
              w_load    = 1'b1;
              w_payload = resp_byte(ACK);
            end else if (bus.rx_data == CMD_HALT) begin
              w_run_nxt     = 1'b0;
              w_err_ovr_nxt = 1'b0;
              w_load        = 1'b1;
              w_payload     = resp_byte(ACK);
            end else if ((bus.rx_data == CMD_STEP) && !r_run) begin
              // ACK follows the step pulse by one cycle
              w_step_nxt = 1'b1;
              w_pend_nxt = 1'b1;
            end else begin
              w_load    = 1'b1;
              w_payload = resp_byte(NAK);
            end
          end
        end
      end

      ST_ARG: begin
        if (bus.rx_valid) begin
          w_tcnt_nxt = '0;
          w_bcnt_nxt = r_bcnt + BCNT_W'(1);
          if (!r_bcnt[2]) w_addr_nxt = {bus.rx_data, r_addr[31:8]};
          else            w_din_nxt  = {bus.rx_data, r_din[31:8]};
          if (is_rd_cmd(r_cmd) && (r_bcnt == BCNT_W'(3))) begin
            if (r_run) begin
              w_load      = 1'b1;
              w_payload   = resp_byte(NAK);
              w_state_nxt = ST_RESP;
            end else begin
              w_wcnt_nxt  = RW_W'(1);
              w_state_nxt = ST_RD_WAIT;
            end
          end else if (r_bcnt == BCNT_W'(7)) begin
            if (r_run) begin
              w_load      = 1'b1;
              w_payload   = resp_byte(NAK);
              w_state_nxt = ST_RESP;
            end else begin
              w_we_im_nxt = (r_cmd == CMD_WR_IM);
              w_we_dm_nxt = (r_cmd == CMD_WR_DM);
              w_state_nxt = ST_WR_SETUP;
            end
          end
        end else if (r_tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + TO_W'(1);
        end
      end

      ST_WR_SETUP: begin
        w_clk_ld_nxt = 1'b1;
        w_state_nxt  = ST_WR_STROBE;
      end

      ST_WR_STROBE: begin
        w_we_im_nxt = 1'b0;
        w_we_dm_nxt = 1'b0;
        w_load      = 1'b1;
        w_payload   = resp_byte(ACK);
        w_state_nxt = ST_RESP;
      end

      ST_RD_WAIT: begin
        if (r_wcnt == RW_W'(READ_WAIT)) begin
          w_load         = 1'b1;
          w_payload.data = w_rd_data;
          w_payload.len  = LEN_W'(RESP_LEN);
          w_state_nxt    = ST_RESP;
        end else begin
          w_wcnt_nxt = r_wcnt + RW_W'(1);
        end
      end

      ST_RESP: begin
        if (r_pend) begin
          w_pend_nxt = 1'b0;
          w_load     = 1'b1;
          w_payload  = resp_byte(ACK);
        end else if (!w_tx_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  sdu_tx_shift u_tx_shift (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (w_load),
    .i_payload (w_payload),
    .i_ready   (bus.tx_ready),
    .o_data    (w_tx_data),
    .o_valid   (w_tx_valid)
  );

  assign bus.tx_data  = w_tx_data;
  assign bus.tx_valid = w_tx_valid;
  assign bus.debug    = r_debug;
  assign bus.addr     = r_addr;
  assign bus.din      = r_din;
  assign bus.we_im    = r_we_im;
  assign bus.we_dm    = r_we_dm;
  assign bus.clk_ld   = r_clk_ld;
  assign bus.run      = r_run;
  assign bus.step     = r_step;
  assign bus.err_ovr  = r_err_ovr;

endmodule

// File: tb/tb_sdu_cmd_ctrl.sv
// Directed bench for sdu_cmd_ctrl: reply bytes are queued as each command is
// sent and compared in order as the transmitter side accepts them.
module tb_sdu_cmd_ctrl;
  import sdu_pkg::*;

  localparam int unsigned RW = 2;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic       seen;
  logic [7:0] sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rdy_mode = 0;

  always #5 clk = ~clk;

  sdu_cmd_ctrl_if bus ();

  sdu_cmd_ctrl #(.READ_WAIT(RW), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // CPU read model
  assign bus.dout_im = bus.addr ^ 32'hC0DE_0000;
  assign bus.dout_dm = (bus.addr == 32'h0000_000C) ? 32'hDEAD_BEEF : ~bus.addr;
  assign bus.dout_rf = {3'b000, bus.addr[4:0] + 5'd3, 3'b000, bus.addr[4:0] + 5'd2,
                        3'b000, bus.addr[4:0] + 5'd1, 3'b000, bus.addr[4:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Transmitter side: drives tx_ready and checks every accepted byte.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ~bus.tx_ready;
      default: bus.tx_ready = 1'b0;
    endcase
    if (rstn && bus.tx_valid && bus.tx_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_errors++;
          $error("FAIL tx_extra: observed byte 0x%02h expected no byte", bus.tx_data);
        end
      end else begin
        chk("tx_byte", 32'(bus.tx_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sb.push_back(w[8*i +: 8]);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.tx_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn         = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_din", bus.din, 32'd0);
    chk("rst_ctl", 32'({bus.we_im, bus.we_dm, bus.clk_ld, bus.run, bus.debug, bus.step, bus.err_ovr}),
        32'b0000100);
    rstn = 1'b1;
    @(negedge clk);

    // Continue / halt
    sb.push_back(ACK);
    send(CMD_RUN);
    chk("run_set", 32'(bus.run), 32'd1);
    chk("run_debug", 32'(bus.debug), 32'd0);
    chk("run_ack_t1", 32'(bus.tx_valid), 32'd1);
    drain("drain_run");
    sb.push_back(ACK);
    send(CMD_HALT);
    chk("halt_clr", 32'(bus.run), 32'd0);
    chk("halt_debug", 32'(bus.debug), 32'd1);
    drain("drain_halt");

    // IM write with timing of we/clk_ld/ACK
    sb.push_back(ACK);
    send(CMD_WR_IM);
    send_word(32'h0000_1000);
    send_word(32'h0050_0013);
    chk("wr_addr", bus.addr, 32'h0000_1000);
    chk("wr_din", bus.din, 32'h0050_0013);
    chk("wr_t1_ctl", 32'({bus.we_im, bus.we_dm, bus.clk_ld, bus.tx_valid}), 32'b1000);
    @(negedge clk);
    chk("wr_t2_ctl", 32'({bus.we_im, bus.we_dm, bus.clk_ld, bus.tx_valid}), 32'b1010);
    @(negedge clk);
    chk("wr_t3_ctl", 32'({bus.we_im, bus.we_dm, bus.clk_ld, bus.tx_valid}), 32'b0001);
    chk("wr_t3_data", 32'(bus.tx_data), 32'(ACK));
    drain("drain_wr_im");
    chk("wr_addr_hold", bus.addr, 32'h0000_1000);

    // DM read with throttled tx_ready
    rdy_mode = 1;
    push_word(32'hDEAD_BEEF);
    send(CMD_RD_DM);
    send_word(32'h0000_000C);
    chk("rd_addr", bus.addr, 32'h0000_000C);
    chk("rd_t1_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    chk("rd_t2_valid", 32'(bus.tx_valid), 32'd0);
    @(negedge clk);
    chk("rd_t3_valid", 32'(bus.tx_valid), 32'd1);
    drain("drain_rd_dm");
    rdy_mode = 0;

    // Regfile read
    push_word(32'h1615_1413);
    send(CMD_RD_RF);
    send_word(32'h0000_0013);
    drain("drain_rd_rf");

    // Step while halted
    sb.push_back(ACK);
    send(CMD_STEP);
    chk("step_t1", 32'({bus.step, bus.tx_valid}), 32'b10);
    @(negedge clk);
    chk("step_t2", 32'({bus.step, bus.tx_valid}), 32'b01);
    drain("drain_step");

    // Commands refused while running
    sb.push_back(ACK);
    send(CMD_RUN);
    drain("drain_run2");
    sb.push_back(NAK);
    send(CMD_STEP);
    chk("step_run", 32'(bus.step), 32'd0);
    drain("drain_step_run");
    sb.push_back(NAK);
    send(CMD_WR_DM);
    send_word(32'h0000_0080);
    send_word(32'h0000_FFFF);
    chk("wr_run_t1", 32'({bus.we_dm, bus.clk_ld}), 32'b00);
    @(negedge clk);
    chk("wr_run_t2", 32'({bus.we_dm, bus.clk_ld}), 32'b00);
    drain("drain_wr_run");
    sb.push_back(ACK);
    send(CMD_HALT);
    drain("drain_halt2");

    // Unknown command
    sb.push_back(NAK);
    send(8'h7A);
    drain("drain_unknown");

    // Argument timeout: no write, no reply, next command decoded
    send(CMD_WR_DM);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    seen = 1'b0;
    repeat (TO + 4) begin
      @(negedge clk);
      if (bus.tx_valid || bus.we_dm || bus.clk_ld) seen = 1'b1;
    end
    chk("to_quiet", 32'(seen), 32'd0);
    sb.push_back(ACK);
    send(CMD_HALT);
    chk("to_halt_ack", 32'(bus.tx_valid), 32'd1);
    drain("drain_to");
    chk("to_err_ovr", 32'(bus.err_ovr), 32'd0);

    // Byte arriving on the terminal count cycle is still accepted
    sb.push_back(ACK);
    send(CMD_WR_DM);
    send(8'h20);
    send(8'h00);
    send(8'h00);
    repeat (TO - 1) @(negedge clk);
    send(8'h00);
    send_word(32'h1234_5678);
    chk("tc_addr", bus.addr, 32'h0000_0020);
    chk("tc_din", bus.din, 32'h1234_5678);
    chk("tc_we", 32'({bus.we_im, bus.we_dm}), 32'b01);
    drain("drain_tc");

    // Overrun during a stalled reply
    rdy_mode = 2;
    push_word(32'hC0DE_0040);
    send(CMD_RD_IM);
    send_word(32'h0000_0040);
    repeat (RW + 2) @(negedge clk);
    chk("ovr_before", 32'(bus.err_ovr), 32'd0);
    send(8'h55);
    chk("ovr_set", 32'(bus.err_ovr), 32'd1);
    rdy_mode = 0;
    drain("drain_ovr");
    chk("ovr_sticky", 32'(bus.err_ovr), 32'd1);
    sb.push_back(ACK);
    send(CMD_HALT);
    chk("ovr_clr", 32'(bus.err_ovr), 32'd0);
    drain("drain_ovr_halt");

    // Asynchronous reset between write setup and strobe
    send(CMD_WR_IM);
    send_word(32'h0000_0044);
    send_word(32'hCAFE_F00D);
    chk("mid_we", 32'(bus.we_im), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'({bus.we_im, bus.we_dm, bus.clk_ld, bus.run, bus.debug, bus.step, bus.err_ovr}),
        32'b0000100);
    chk("mid_rst_addr", bus.addr, 32'd0);
    chk("mid_rst_din", bus.din, 32'd0);
    chk("mid_rst_tx", 32'({bus.tx_valid, bus.tx_data}), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.clk_ld || bus.tx_valid) seen = 1'b1;
    end
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.clk_ld || bus.tx_valid) seen = 1'b1;
    end
    chk("mid_no_pulse", 32'(seen), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
